// File: rtl/fifo_demux_rx.sv
// Packet-aware receive demultiplexer: pops framed packets from one FWFT input FIFO and steers
// each whole packet into one of NCH client FIFOs, selected by the header's channel field.

module fifo #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          CLK,
   input  logic          RESETn,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          empty,
   output logic          full
);
   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_wr, do_rd;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign rd_data = mem_q[rptr_q];
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_wr) wptr_d = wptr_q + AW'(1);
      if (do_rd) rptr_d = rptr_q + AW'(1);
      if (do_wr && !do_rd) cnt_d = cnt_q + (AW+1)'(1);
      if (!do_wr && do_rd) cnt_d = cnt_q - (AW+1)'(1);
   end

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage is not reset; the empty flag hides stale contents.
   always_ff @(posedge CLK) begin
      if (do_wr) mem_q[wptr_q] <= wr_data;
   end
endmodule

module fifo_demux_rx #(
   parameter int NCH     = 4,
   parameter int DWIDTH  = 8,
   parameter int AWIDTH  = 3,
   parameter int SEL_LSB = 6,
   parameter int SEL_W   = 2,
   parameter int CNT_LSB = 3,
   parameter int CNT_W   = 3
) (
   input  logic                    CLK,
   input  logic                    RESETn,
   output logic                    fifo_rden,
   input  logic                    fifo_rdempty,
   input  logic [DWIDTH-1:0]       fifo_rddata,
   input  logic [NCH-1:0]          ch_rden,
   output logic [NCH-1:0]          ch_rdempty,
   output logic [NCH*DWIDTH-1:0]   ch_rddata,
   output logic                    drop_pulse,
   output logic                    busy
);
   if (NCH < 2 || NCH > 16) begin : g_err_nch
      $error("fifo_demux_rx: NCH must be 2..16");
   end
   if ((1 << SEL_W) < NCH) begin : g_err_selw
      $error("fifo_demux_rx: channel field too narrow for NCH");
   end
   if (SEL_LSB + SEL_W > DWIDTH || CNT_LSB + CNT_W > DWIDTH) begin : g_err_range
      $error("fifo_demux_rx: header field exceeds DWIDTH");
   end
   if (!(SEL_LSB + SEL_W <= CNT_LSB || CNT_LSB + CNT_W <= SEL_LSB)) begin : g_err_overlap
      $error("fifo_demux_rx: channel and count fields overlap");
   end

   typedef enum logic [1:0] {S_HDR, S_DATA, S_DROP} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       rem_q, rem_d;
   logic [SEL_W-1:0]       dst_q, dst_d;
   logic [SEL_W-1:0]       hdr_dst, wr_dst;
   logic [CNT_W-1:0]       hdr_len;
   logic                   hdr_valid, wr_sel;
   logic [NCH-1:0]         ch_full, wr_en;
   logic [(1<<SEL_W)-1:0]  full_ext;

   assign hdr_dst   = fifo_rddata[SEL_LSB +: SEL_W];
   assign hdr_len   = fifo_rddata[CNT_LSB +: CNT_W];
   assign hdr_valid = (32'(hdr_dst) < NCH);
   assign busy      = (state_q != S_HDR);

   // Unused channel codes read as never-full so the index is always in range.
   always_comb begin
      full_ext = '0;
      full_ext[NCH-1:0] = ch_full;
   end

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      dst_d      = dst_q;
      fifo_rden  = 1'b0;
      drop_pulse = 1'b0;
      wr_sel     = 1'b0;
      wr_dst     = dst_q;
      case (state_q)
         S_HDR: begin
            if (hdr_valid) begin
               fifo_rden = !fifo_rdempty && !full_ext[hdr_dst];
               if (fifo_rden) begin
                  wr_sel = 1'b1;
                  wr_dst = hdr_dst;
                  dst_d  = hdr_dst;
                  rem_d  = hdr_len;
                  if (hdr_len != '0) state_d = S_DATA;
               end
            end else begin
               fifo_rden = !fifo_rdempty;
               if (fifo_rden) begin
                  drop_pulse = 1'b1;
                  rem_d      = hdr_len;
                  if (hdr_len != '0) state_d = S_DROP;
               end
            end
         end
         S_DATA, S_DROP: begin
            fifo_rden = !fifo_rdempty && ((state_q == S_DROP) || !full_ext[dst_q]);
            if (fifo_rden) begin
               wr_sel = (state_q == S_DATA);
               if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
               if (rem_q <= CNT_W'(1)) state_d = S_HDR;
            end
         end
         default: state_d = S_HDR;
      endcase
      // No input word may be consumed while reset is held.
      if (!RESETn) begin
         fifo_rden  = 1'b0;
         drop_pulse = 1'b0;
         wr_sel     = 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
         wr_en[i] = wr_sel && (32'(wr_dst) == i);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         state_q <= S_HDR;
         rem_q   <= '0;
         dst_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         dst_q   <= dst_d;
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      fifo #(.DW(DWIDTH), .AW(AWIDTH)) u_fifo (
         .CLK     (CLK),
         .RESETn  (RESETn),
         .wr_en   (wr_en[g]),
         .wr_data (fifo_rddata),
         .rd_en   (ch_rden[g]),
         .rd_data (ch_rddata[g*DWIDTH +: DWIDTH]),
         .empty   (ch_rdempty[g]),
         .full    (ch_full[g])
      );
   end
endmodule

// File: tb/tb_fifo_demux_rx.sv
// Directed bench for fifo_demux_rx: a 4-channel instance for routing/stall/reset scenarios and a
// 3-channel instance for invalid-channel drops; the input FIFO is a FWFT queue model.

module tb_fifo_demux_rx;
  logic        clk, rstn;
  logic        rden_a, empty_a, drop_a, busy_a;
  logic [7:0]  data_a;
  logic [3:0]  ch_rden_a, ch_empty_a;
  logic [31:0] ch_data_a;
  logic        rden_b, empty_b, drop_b, busy_b;
  logic [7:0]  data_b;
  logic [2:0]  ch_rden_b, ch_empty_b;
  logic [23:0] ch_data_b;

  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];
  int          n_checks = 0;
  int          n_fail = 0;

  fifo_demux_rx dut_a (
    .CLK(clk), .RESETn(rstn), .fifo_rden(rden_a), .fifo_rdempty(empty_a), .fifo_rddata(data_a),
    .ch_rden(ch_rden_a), .ch_rdempty(ch_empty_a), .ch_rddata(ch_data_a),
    .drop_pulse(drop_a), .busy(busy_a)
  );

  fifo_demux_rx #(.NCH(3)) dut_b (
    .CLK(clk), .RESETn(rstn), .fifo_rden(rden_b), .fifo_rdempty(empty_b), .fifo_rddata(data_b),
    .ch_rden(ch_rden_b), .ch_rdempty(ch_empty_b), .ch_rddata(ch_data_b),
    .drop_pulse(drop_b), .busy(busy_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FWFT input FIFO models
  task automatic refresh();
    empty_a = (q_a.size() == 0);
    data_a  = empty_a ? 8'h00 : q_a[0];
    empty_b = (q_b.size() == 0);
    data_b  = empty_b ? 8'h00 : q_b[0];
  endtask

  always begin
    @(posedge clk);
    if (rden_a && q_a.size() > 0) void'(q_a.pop_front());
    if (rden_b && q_b.size() > 0) void'(q_b.pop_front());
    #1;
    refresh();
  end

  task automatic push_a(input logic [7:0] w);
    q_a.push_back(w);
    refresh();
  endtask

  task automatic push_b(input logic [7:0] w);
    q_b.push_back(w);
    refresh();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rden_a !== 1'b0) begin n_fail++; $display("FAIL reset_rden got %b exp 0", rden_a); end
    n_checks++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    n_checks++;
    if (ch_empty_a !== 4'hF) begin n_fail++; $display("FAIL reset_empty got %b exp 1111", ch_empty_a); end
    n_checks++;
    if (drop_a !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %b exp 0", drop_a); end
    n_checks++;
    if (ch_empty_b !== 3'h7) begin n_fail++; $display("FAIL reset_empty_b got %b exp 111", ch_empty_b); end
    rstn = 1'b1;
  endtask

  task automatic test_route();
    logic [7:0] exp [3];
    exp[0] = 8'h50; exp[1] = 8'hAA; exp[2] = 8'hBB;
    push_a(8'h50); push_a(8'hAA); push_a(8'hBB);
    #1;
    n_checks++;
    if (rden_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL route_hdr rden/busy got %b/%b exp 1/0", rden_a, busy_a);
    end
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL route_busy1 got %b exp 1", busy_a); end
    n_checks++;
    if (ch_empty_a !== 4'b1101) begin n_fail++; $display("FAIL route_hdr_lat got %b exp 1101", ch_empty_a); end
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL route_busy2 got %b exp 1", busy_a); end
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0 || rden_a !== 1'b0) begin
      n_fail++; $display("FAIL route_end busy/rden got %b/%b exp 0/0", busy_a, rden_a);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ch_data_a[15:8] !== exp[i]) begin
        n_fail++; $display("FAIL route_data%0d got %h exp %h", i, ch_data_a[15:8], exp[i]);
      end
      ch_rden_a = 4'b0010;
      @(negedge clk);
    end
    ch_rden_a = 4'b0000;
    n_checks++;
    if (ch_empty_a !== 4'hF) begin n_fail++; $display("FAIL route_drained got %b exp 1111", ch_empty_a); end
  endtask

  task automatic test_isolation();
    logic [7:0] exp2 [8];
    for (int i = 0; i < 8; i++) begin
      push_a(8'h80 + 8'(i));
      exp2[i] = (i == 7) ? 8'h80 : 8'h81 + 8'(i);
    end
    push_a(8'h80); push_a(8'h08); push_a(8'h11);
    repeat (8) @(negedge clk);
    n_checks++;
    if (rden_a !== 1'b0) begin n_fail++; $display("FAIL iso_stall got %b exp 0", rden_a); end
    n_checks++;
    if (ch_empty_a !== 4'b1011) begin n_fail++; $display("FAIL iso_empty got %b exp 1011", ch_empty_a); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (rden_a !== 1'b0) begin n_fail++; $display("FAIL iso_stall_hold got %b exp 0", rden_a); end
    n_checks++;
    if (ch_data_a[23:16] !== 8'h80) begin n_fail++; $display("FAIL iso_head got %h exp 80", ch_data_a[23:16]); end
    ch_rden_a = 4'b0100;
    @(negedge clk);
    ch_rden_a = 4'b0000;
    n_checks++;
    if (rden_a !== 1'b1) begin n_fail++; $display("FAIL iso_resume got %b exp 1", rden_a); end
    @(negedge clk);
    n_checks++;
    if (rden_a !== 1'b1 || ch_empty_a !== 4'b1011) begin
      n_fail++; $display("FAIL iso_ch0_hdr rden/empty got %b/%b exp 1/1011", rden_a, ch_empty_a);
    end
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b1 || ch_empty_a !== 4'b1010) begin
      n_fail++; $display("FAIL iso_ch0_data busy/empty got %b/%b exp 1/1010", busy_a, ch_empty_a);
    end
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL iso_done got %b exp 0", busy_a); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (ch_data_a[23:16] !== exp2[i]) begin
        n_fail++; $display("FAIL iso_ch2_data%0d got %h exp %h", i, ch_data_a[23:16], exp2[i]);
      end
      ch_rden_a = 4'b0100;
      @(negedge clk);
    end
    ch_rden_a = 4'b0000;
    n_checks++;
    if (ch_data_a[7:0] !== 8'h08) begin n_fail++; $display("FAIL iso_ch0_d0 got %h exp 08", ch_data_a[7:0]); end
    ch_rden_a = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (ch_data_a[7:0] !== 8'h11) begin n_fail++; $display("FAIL iso_ch0_d1 got %h exp 11", ch_data_a[7:0]); end
    @(negedge clk);
    ch_rden_a = 4'b0000;
    n_checks++;
    if (ch_empty_a !== 4'hF) begin n_fail++; $display("FAIL iso_drained got %b exp 1111", ch_empty_a); end
  endtask

  task automatic test_invalid();
    int drops;
    push_b(8'hD0); push_b(8'h01); push_b(8'h02); push_b(8'h00);
    #1;
    n_checks++;
    if (drop_b !== 1'b1 || rden_b !== 1'b1) begin
      n_fail++; $display("FAIL inv_hdr drop/rden got %b/%b exp 1/1", drop_b, rden_b);
    end
    drops = int'(drop_b);
    @(negedge clk);
    n_checks++;
    if (busy_b !== 1'b1) begin n_fail++; $display("FAIL inv_busy got %b exp 1", busy_b); end
    drops += int'(drop_b);
    repeat (3) begin
      @(negedge clk);
      drops += int'(drop_b);
    end
    n_checks++;
    if (drops != 1) begin n_fail++; $display("FAIL inv_drop_count got %0d exp 1", drops); end
    n_checks++;
    if (ch_empty_b !== 3'b110 || busy_b !== 1'b0) begin
      n_fail++; $display("FAIL inv_after empty/busy got %b/%b exp 110/0", ch_empty_b, busy_b);
    end
    n_checks++;
    if (ch_data_b[7:0] !== 8'h00) begin n_fail++; $display("FAIL inv_ch0_data got %h exp 00", ch_data_b[7:0]); end
    ch_rden_b = 3'b001;
    @(negedge clk);
    ch_rden_b = 3'b000;
    n_checks++;
    if (ch_empty_b !== 3'b111) begin n_fail++; $display("FAIL inv_drained got %b exp 111", ch_empty_b); end
  endtask

  task automatic test_back_to_back();
    push_a(8'h00); push_a(8'h40); push_a(8'h80);
    #1;
    n_checks++;
    if (rden_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL b2b_start rden/busy got %b/%b exp 1/0", rden_a, busy_a);
    end
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0 || ch_empty_a !== 4'b1110) begin
      n_fail++; $display("FAIL b2b_c1 busy/empty got %b/%b exp 0/1110", busy_a, ch_empty_a);
    end
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0 || ch_empty_a !== 4'b1100) begin
      n_fail++; $display("FAIL b2b_c2 busy/empty got %b/%b exp 0/1100", busy_a, ch_empty_a);
    end
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0 || ch_empty_a !== 4'b1000 || rden_a !== 1'b0) begin
      n_fail++; $display("FAIL b2b_c3 busy/empty/rden got %b/%b/%b exp 0/1000/0", busy_a, ch_empty_a, rden_a);
    end
    n_checks++;
    if (ch_data_a[23:0] !== 24'h804000) begin
      n_fail++; $display("FAIL b2b_data got %h exp 804000", ch_data_a[23:0]);
    end
    ch_rden_a = 4'b0111;
    @(negedge clk);
    ch_rden_a = 4'b0000;
    n_checks++;
    if (ch_empty_a !== 4'hF) begin n_fail++; $display("FAIL b2b_drained got %b exp 1111", ch_empty_a); end
  endtask

  task automatic test_mid_reset();
    push_a(8'h78); push_a(8'h01); push_a(8'h02); push_a(8'h03);
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b1 || ch_empty_a !== 4'b1101) begin
      n_fail++; $display("FAIL midrst_pre busy/empty got %b/%b exp 1/1101", busy_a, ch_empty_a);
    end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_checks++;
    if (ch_empty_a !== 4'hF || busy_a !== 1'b0 || rden_a !== 1'b0) begin
      n_fail++; $display("FAIL midrst_post empty/busy/rden got %b/%b/%b exp 1111/0/0", ch_empty_a, busy_a, rden_a);
    end
    push_a(8'h40);
    #1;
    n_checks++;
    if (rden_a !== 1'b1) begin n_fail++; $display("FAIL midrst_hdr_rden got %b exp 1", rden_a); end
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0 || ch_empty_a !== 4'b1101 || ch_data_a[15:8] !== 8'h40) begin
      n_fail++; $display("FAIL midrst_route busy/empty/data got %b/%b/%h exp 0/1101/40", busy_a, ch_empty_a, ch_data_a[15:8]);
    end
    ch_rden_a = 4'b0010;
    @(negedge clk);
    ch_rden_a = 4'b0000;
    n_checks++;
    if (ch_empty_a !== 4'hF) begin n_fail++; $display("FAIL midrst_drained got %b exp 1111", ch_empty_a); end
  endtask

  initial begin
    rstn = 1'b0;
    ch_rden_a = 4'b0000;
    ch_rden_b = 3'b000;
    refresh();
    test_reset();
    @(negedge clk);
    test_route();
    test_isolation();
    test_invalid();
    test_back_to_back();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
